uart_tx_buffered: RTL and testbench

//  UART transmitter downstream of the RX/ALU command interface. Captures the
//  8-bit ALU result on a 1-clk ready strobe, serialises it as 8N1 (configurable

---
 rtl/uart_tx_buffered_pkg.sv | 23 ++
 rtl/uart_tx_buffered.sv | 147 ++++++++++++++
 tb/tb_uart_tx_buffered.sv | 305 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_buffered_pkg.sv
// Shared UART definitions: FSM state encodings and default timing constants,
// common to the transmitter and its receive-side sibling.
package uart_tx_buffered_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    START = 2'b01,
    DATA  = 2'b10,
    STOP  = 2'b11
  } tx_state_t;

  localparam int DEF_NB_DATA    = 8;
  localparam int DEF_OVERSAMPLE = 16;
  localparam int DEF_SB_TICK    = 16;

  // One tick counter serves both bit and stop periods, so size it for the longer one.
  function automatic int tick_width(input int oversample, input int sb_tick);
    int m;
    m = (oversample > sb_tick) ? oversample : sb_tick;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/uart_tx_buffered.sv
// 8N1 UART transmitter paced by an external oversampling tick, with a one-deep
// pending byte so a result arriving mid-frame follows without an idle gap.
module uart_tx_buffered
  import uart_tx_buffered_pkg::*;
#(
  parameter int NB_DATA    = DEF_NB_DATA,
  parameter int OVERSAMPLE = DEF_OVERSAMPLE,
  parameter int SB_TICK    = DEF_SB_TICK
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_tick,
  input  logic               i_tx_start,
  input  logic [NB_DATA-1:0] i_data,
  output logic               o_tx,
  output logic               o_tx_done,
  output logic               o_busy,
  output logic               o_overrun,
  output tx_state_t          o_state
);

  localparam int TW = tick_width(OVERSAMPLE, SB_TICK);
  localparam int BW = (NB_DATA > 1) ? $clog2(NB_DATA) : 1;
  localparam logic [TW-1:0] OS_LAST  = TW'(OVERSAMPLE - 1);
  localparam logic [TW-1:0] SB_LAST  = TW'(SB_TICK - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(NB_DATA - 1);

  tx_state_t          state, state_n;
  logic [TW-1:0]      tick_cnt, tick_n;
  logic [BW-1:0]      bit_cnt, bit_n;
  logic [NB_DATA-1:0] shift, shift_n;
  logic [NB_DATA-1:0] pend_data, pend_n;
  logic               pend_valid, pend_v_n;
  logic               tx_reg, tx_c;
  logic               done_c, overrun_c;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state      <= IDLE;
      tick_cnt   <= '0;
      bit_cnt    <= '0;
      shift      <= '0;
      pend_data  <= '0;
      pend_valid <= 1'b0;
      tx_reg     <= 1'b1;
    end else begin
      state      <= state_n;
      tick_cnt   <= tick_n;
      bit_cnt    <= bit_n;
      shift      <= shift_n;
      pend_data  <= pend_n;
      pend_valid <= pend_v_n;
      tx_reg     <= tx_c;
    end
  end

  always_comb begin
    state_n   = state;
    tick_n    = tick_cnt;
    bit_n     = bit_cnt;
    shift_n   = shift;
    pend_n    = pend_data;
    pend_v_n  = pend_valid;
    tx_c      = 1'b1;
    done_c    = 1'b0;
    overrun_c = 1'b0;

    case (state)
      IDLE: begin
        if (i_tx_start) begin
          shift_n = i_data;
          state_n = START;
          tick_n  = '0;
        end
      end
      START: begin
        tx_c = 1'b0;
        if (i_tick) begin
          if (tick_cnt == OS_LAST) begin
            state_n = DATA;
            tick_n  = '0;
            bit_n   = '0;
          end else begin
            tick_n = tick_cnt + TW'(1);
          end
        end
      end
      DATA: begin
        tx_c = shift[0];
        if (i_tick) begin
          if (tick_cnt == OS_LAST) begin
            tick_n  = '0;
            shift_n = shift >> 1;
            if (bit_cnt == BIT_LAST) begin
              state_n = STOP;
            end else begin
              bit_n = bit_cnt + BW'(1);
            end
          end else begin
            tick_n = tick_cnt + TW'(1);
          end
        end
      end
      STOP: begin
        if (i_tick) begin
          if (tick_cnt == SB_LAST) begin
            done_c = 1'b1;
            tick_n = '0;
            // A start landing on the completion cycle queues behind any pending byte.
            if (pend_valid) begin
              shift_n  = pend_data;
              state_n  = START;
              pend_v_n = i_tx_start;
              if (i_tx_start) begin
                pend_n = i_data;
              end
            end else if (i_tx_start) begin
              shift_n = i_data;
              state_n = START;
            end else begin
              state_n = IDLE;
            end
          end else begin
            tick_n = tick_cnt + TW'(1);
          end
        end
      end
      default: state_n = IDLE;
    endcase

    if (i_tx_start && (state != IDLE) && !done_c) begin
      if (!pend_valid) begin
        pend_n   = i_data;
        pend_v_n = 1'b1;
      end else begin
        overrun_c = 1'b1;
      end
    end
  end

  assign o_tx      = tx_reg;
  assign o_tx_done = done_c;
  assign o_busy    = (state != IDLE);
  assign o_overrun = overrun_c;
  assign o_state   = state;

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Self-checking bench for uart_tx_buffered: table-driven single frames plus
// hand-written back-to-back, overrun, completion-cycle, reset and 2-stop cases.
module tb_uart_tx_buffered;
  import uart_tx_buffered_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       tick = 1'b0;
  logic       start = 1'b0;
  logic [7:0] data = 8'h00;
  logic       tx, done, busy, ovr;
  tx_state_t  st;

  logic       start2 = 1'b0;
  logic [7:0] data2 = 8'h00;
  logic       tx2, done2, busy2, ovr2;
  tx_state_t  st2;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int done_cnt = 0;
  int ovr_cnt = 0;
  int last_done_cyc = 0;
  logic [1:0] phase = 2'd0;

  uart_tx_buffered #(.NB_DATA(8), .OVERSAMPLE(16), .SB_TICK(16)) dut (
    .i_clk(clk), .i_reset(reset), .i_tick(tick), .i_tx_start(start), .i_data(data),
    .o_tx(tx), .o_tx_done(done), .o_busy(busy), .o_overrun(ovr), .o_state(st)
  );

  uart_tx_buffered #(.NB_DATA(8), .OVERSAMPLE(16), .SB_TICK(32)) dut2 (
    .i_clk(clk), .i_reset(reset), .i_tick(tick), .i_tx_start(start2), .i_data(data2),
    .o_tx(tx2), .o_tx_done(done2), .o_busy(busy2), .o_overrun(ovr2), .o_state(st2)
  );

  // Clock/reset block and 1-in-4 tick
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial forever begin
    @(negedge clk);
    tick  = (phase == 2'd3);
    phase = phase + 2'd1;
  end

  // Pulse monitor, sampled just after the falling edge once inputs have settled
  initial forever begin
    @(negedge clk);
    #1;
    if (done) begin
      done_cnt      = done_cnt + 1;
      last_done_cyc = cyc;
    end
    if (ovr) ovr_cnt = ovr_cnt + 1;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    n_cmp++;
    if (act < lo || act > hi) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  // Driver: one-cycle start strobe; returns the cycle count just after the capturing edge
  task automatic send(input logic [7:0] b, output int sc);
    @(negedge clk);
    start = 1'b1;
    data  = b;
    @(negedge clk);
    sc    = cyc;
    start = 1'b0;
    data  = 8'($urandom_range(0, 255));
  endtask

  // Receiver: waits for the start bit, then samples mid-bit: {stop, d7..d0, start}
  task automatic recv_line(input string name, output logic [9:0] line, output int gap);
    int n;
    n = 0;
    line = '1;
    while (tx !== 1'b0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    gap = n;
    check({name, "_start_seen"}, 32'(n < 3000), 32'd1);
    repeat (32) @(negedge clk);
    line[0] = tx;
    for (int i = 1; i < 10; i++) begin
      repeat (64) @(negedge clk);
      line[i] = tx;
    end
  endtask

  typedef struct {
    logic [7:0] data;
    logic [9:0] line;
  } vec_t;

  vec_t vecs[6];
  logic [9:0] line_a, line_b;
  int gap_a, gap_b, sc, d0, o0, n, lows, highs;

  initial begin
    vecs[0] = '{8'h35, 10'b1_0011_0101_0};
    vecs[1] = '{8'h00, 10'b1_0000_0000_0};
    vecs[2] = '{8'hFF, 10'b1_1111_1111_0};
    vecs[3] = '{8'hA5, 10'b1_1010_0101_0};
    vecs[4] = '{8'h80, 10'b1_1000_0000_0};
    vecs[5] = '{8'h01, 10'b1_0000_0001_0};

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    check("reset_tx", 32'(tx), 32'd1);
    check("reset_done", 32'(done), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_overrun", 32'(ovr), 32'd0);
    check("reset_state", 32'(st), 32'(IDLE));
    @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);

    // Single frames from idle
    for (int v = 0; v < 6; v++) begin
      d0 = done_cnt;
      send(vecs[v].data, sc);
      check($sformatf("v%0d_tx_hold", v), 32'(tx), 32'd1);
      check($sformatf("v%0d_busy", v), 32'(busy), 32'd1);
      @(negedge clk);
      check($sformatf("v%0d_tx_low", v), 32'(tx), 32'd0);
      recv_line($sformatf("v%0d", v), line_a, gap_a);
      check($sformatf("v%0d_line", v), 32'(line_a), 32'(vecs[v].line));
      repeat (40) @(negedge clk);
      #1;
      check($sformatf("v%0d_done_count", v), 32'(done_cnt - d0), 32'd1);
      check_range($sformatf("v%0d_done_time", v), last_done_cyc - sc, 636, 640);
      check($sformatf("v%0d_busy_after", v), 32'(busy), 32'd0);
    end

    // Back-to-back via pending register
    d0 = done_cnt; o0 = ovr_cnt;
    fork
      begin
        int s1;
        send(8'hA1, s1);
        repeat (99) @(negedge clk);
        send(8'h5C, s1);
      end
      begin
        recv_line("b2b_1", line_a, gap_a);
        recv_line("b2b_2", line_b, gap_b);
      end
    join
    check("b2b_line1", 32'(line_a), 32'(10'b1_1010_0001_0));
    check("b2b_line2", 32'(line_b), 32'(10'b1_0101_1100_0));
    check_range("b2b_gap", gap_b, 28, 33);
    repeat (40) @(negedge clk);
    #1;
    check("b2b_done_count", 32'(done_cnt - d0), 32'd2);
    check("b2b_overrun", 32'(ovr_cnt - o0), 32'd0);

    // Third start while pending is full is dropped
    d0 = done_cnt; o0 = ovr_cnt;
    fork
      begin
        int s1;
        send(8'h11, s1);
        repeat (99) @(negedge clk);
        send(8'h22, s1);
        repeat (99) @(negedge clk);
        send(8'h33, s1);
      end
      begin
        recv_line("ovr_1", line_a, gap_a);
        recv_line("ovr_2", line_b, gap_b);
      end
    join
    check("ovr_line1", 32'(line_a), 32'(10'b1_0001_0001_0));
    check("ovr_line2", 32'(line_b), 32'(10'b1_0010_0010_0));
    repeat (40) @(negedge clk);
    #1;
    check("ovr_pulses", 32'(ovr_cnt - o0), 32'd1);
    check("ovr_done_count", 32'(done_cnt - d0), 32'd2);
    lows = 0;
    repeat (700) begin
      @(negedge clk);
      if (tx !== 1'b1) lows++;
    end
    check("ovr_no_third_frame", 32'(lows), 32'd0);
    check("ovr_busy_after", 32'(busy), 32'd0);

    // Start exactly on the stop-completion cycle with pending empty
    d0 = done_cnt; o0 = ovr_cnt;
    fork
      begin
        int s1;
        send(8'h0F, s1);
        n = 0;
        do begin
          @(negedge clk);
          #1;
          n++;
        end while (!done && n < 1000);
        check("cmp_done_seen", 32'(n < 1000), 32'd1);
        start = 1'b1;
        data  = 8'h7E;
        @(negedge clk);
        start = 1'b0;
        data  = 8'($urandom_range(0, 255));
      end
      begin
        recv_line("cmp_1", line_a, gap_a);
        recv_line("cmp_2", line_b, gap_b);
      end
    join
    check("cmp_line1", 32'(line_a), 32'(10'b1_0000_1111_0));
    check("cmp_line2", 32'(line_b), 32'(10'b1_0111_1110_0));
    check_range("cmp_gap", gap_b, 28, 33);
    repeat (40) @(negedge clk);
    #1;
    check("cmp_overrun", 32'(ovr_cnt - o0), 32'd0);
    check("cmp_done_count", 32'(done_cnt - d0), 32'd2);

    // Reset mid-DATA with a pending byte
    d0 = done_cnt;
    send(8'hFF, sc);
    repeat (99) @(negedge clk);
    send(8'h01, sc);
    repeat (100) @(negedge clk);
    check("rst_state_data", 32'(st), 32'(DATA));
    #2;
    reset = 1'b1;
    #1;
    check("rst_tx_high", 32'(tx), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    lows = 0;
    repeat (1000) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0) lows++;
    end
    check("rst_quiet", 32'(lows), 32'd0);
    check("rst_no_done", 32'(done_cnt - d0), 32'd0);
    send(8'h3C, sc);
    recv_line("rst_next", line_a, gap_a);
    check("rst_next_line", 32'(line_a), 32'(10'b1_0011_1100_0));
    repeat (40) @(negedge clk);

    // Two stop bits on the second instance
    @(negedge clk);
    start2 = 1'b1;
    data2  = 8'h00;
    @(negedge clk);
    start2 = 1'b0;
    data2  = 8'($urandom_range(0, 255));
    n = 0;
    while (tx2 !== 1'b0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("sb2_start_seen", 32'(n < 100), 32'd1);
    lows = 0;
    while (tx2 === 1'b0 && lows < 1000) begin
      @(negedge clk);
      lows++;
    end
    check_range("sb2_low_len", lows, 572, 577);
    highs = 0;
    n = 0;
    do begin
      @(negedge clk);
      #1;
      highs++;
      if (tx2 !== 1'b1) n++;
    end while (!done2 && highs < 1000);
    check_range("sb2_stop_len", highs, 124, 128);
    check("sb2_stop_high", 32'(n), 32'd0);
    @(negedge clk);
    #1;
    check("sb2_busy_after", 32'(busy2), 32'd0);
    check("sb2_tx_idle", 32'(tx2), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
